// File: rtl/gpio_input_irq.sv
// Input half of the GPIO block: synchronizes pad levels, detects per-pin edge/level events,
// keeps sticky write-1-to-clear status and drives the per-pin and aggregated interrupts.
module gpio_input_irq #(
    parameter int NUM_PINS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic [NUM_PINS-1:0] pin_in,
    input  logic [NUM_PINS-1:0] int_en,
    input  logic [NUM_PINS-1:0] int_type,
    input  logic [NUM_PINS-1:0] int_pol,
    input  logic [NUM_PINS-1:0] int_both,
    input  logic                clr_wen,
    input  logic [NUM_PINS-1:0] clr_mask,
    output logic [NUM_PINS-1:0] r_data,
    output logic [NUM_PINS-1:0] status,
    output logic [NUM_PINS-1:0] interrupt,
    output logic                irq
);

    localparam logic [2:0] WARM_END = 3'(SYNC_STAGES + 1);

    logic [NUM_PINS-1:0] sync_q [SYNC_STAGES];
    logic [NUM_PINS-1:0] sync_d [SYNC_STAGES];
    logic [NUM_PINS-1:0] prev_q, prev_d;
    logic [NUM_PINS-1:0] status_q, status_d;
    logic [2:0]          warm_q, warm_d;

    logic [NUM_PINS-1:0] s;
    logic [NUM_PINS-1:0] rise, fall;
    logic [NUM_PINS-1:0] edge_evt, level_evt, evt;
    logic [NUM_PINS-1:0] clr_bits;
    logic [NUM_PINS-1:0] int_vec;
    logic                warm_done;

    always_comb begin
        sync_d[0] = pin_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign s      = sync_q[SYNC_STAGES-1];
    assign prev_d = s;
    assign rise   = s & ~prev_q;
    assign fall   = ~s & prev_q;

    // Events stay masked until the synchronizer and prev have both been filled with real pin data.
    assign warm_done = (warm_q == WARM_END);
    assign warm_d    = warm_done ? warm_q : warm_q + 3'd1;

    always_comb begin
        edge_evt  = (int_both & (rise | fall)) |
                    (~int_both & ((int_pol & rise) | (~int_pol & fall)));
        level_evt = (int_pol & s) | (~int_pol & ~s);
        evt       = '0;
        if (warm_done) begin
            evt = (int_type & edge_evt) | (~int_type & level_evt);
        end
    end

    // A new event on a bit overrides a simultaneous clear of that bit.
    always_comb begin
        clr_bits = clr_wen ? clr_mask : '0;
        status_d = (evt & int_en) | (status_q & ~clr_bits);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q   <= '0;
            status_q <= '0;
            warm_q   <= '0;
        end else begin
            sync_q   <= sync_d;
            prev_q   <= prev_d;
            status_q <= status_d;
            warm_q   <= warm_d;
        end
    end

    assign int_vec   = status_q & int_en;
    assign r_data    = s;
    assign status    = status_q;
    assign interrupt = int_vec;
    assign irq       = |int_vec;

endmodule

// File: tb/tb_gpio_input_irq.sv
// Self-checking bench for gpio_input_irq: directed vector table, hand-written corner sequences,
// and randomized traffic compared against a pin-history based reference model.
module tb_gpio_input_irq;

    localparam int NP   = 8;
    localparam int SYNC = 2;

    logic          CLK;
    logic          nRST;
    logic [NP-1:0] pin_in, int_en, int_type, int_pol, int_both, clr_mask;
    logic          clr_wen;
    logic [NP-1:0] r_data, status, interrupt;
    logic          irq;

    int checks;
    int errors;

    gpio_input_irq #(.NUM_PINS(NP), .SYNC_STAGES(SYNC)) dut (
        .CLK(CLK), .nRST(nRST), .pin_in(pin_in), .int_en(int_en), .int_type(int_type),
        .int_pol(int_pol), .int_both(int_both), .clr_wen(clr_wen), .clr_mask(clr_mask),
        .r_data(r_data), .status(status), .interrupt(interrupt), .irq(irq)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: remembers the pins sampled at recent edges and applies the event rules per bit.
    logic [NP-1:0] pinHist[$];
    logic [NP-1:0] mStatus;
    int            mEdges;

    function automatic logic [NP-1:0] histAt(int k);
        if (k < pinHist.size()) return pinHist[k];
        return '0;
    endfunction

    always @(posedge CLK or negedge nRST) begin : refModel
        logic [NP-1:0] sv, pv;
        logic          evt, rose, fell;
        if (!nRST) begin
            mStatus = '0;
            pinHist.delete();
            mEdges  = 0;
        end else begin
            sv = histAt(SYNC - 1);
            pv = histAt(SYNC);
            for (int b = 0; b < NP; b++) begin
                evt = 1'b0;
                if (mEdges >= SYNC + 1) begin
                    if (int_type[b]) begin
                        rose = sv[b] && !pv[b];
                        fell = !sv[b] && pv[b];
                        if (int_both[b]) evt = rose || fell;
                        else             evt = int_pol[b] ? rose : fell;
                    end else begin
                        evt = int_pol[b] ? sv[b] : !sv[b];
                    end
                end
                if (evt && int_en[b])              mStatus[b] = 1'b1;
                else if (clr_wen && clr_mask[b])   mStatus[b] = 1'b0;
            end
            pinHist.push_front(pin_in);
            if (pinHist.size() > SYNC + 1) void'(pinHist.pop_back());
            if (mEdges < 1000) mEdges++;
        end
    end

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkModel(string tag);
        logic [NP-1:0] expInt;
        expInt = mStatus & int_en;
        checkOutput({tag, "_r_data"},    32'(r_data),    32'(histAt(SYNC - 1)));
        checkOutput({tag, "_status"},    32'(status),    32'(mStatus));
        checkOutput({tag, "_interrupt"}, 32'(interrupt), 32'(expInt));
        checkOutput({tag, "_irq"},       32'(irq),       32'(|expInt));
    endtask

    task automatic applyStimulus(logic [NP-1:0] pins, logic clr, logic [NP-1:0] mask);
        pin_in   = pins;
        clr_wen  = clr;
        clr_mask = mask;
    endtask

    task automatic stepCycles(int n, string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            checkModel(tag);
            clr_wen = 1'b0;
        end
    endtask

    typedef struct {
        logic [NP-1:0] pin;
        logic          clr;
        logic [NP-1:0] mask;
        logic [NP-1:0] expR;
        logic [NP-1:0] expS;
        logic          expIrq;
    } vec_t;

    vec_t vecs[13];

    initial begin
        checks = 0;
        errors = 0;

        // Cycle-by-cycle expectations after reset release, all pins rising-edge, enabled.
        vecs[0]  = '{8'hFF, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[1]  = '{8'hFF, 1'b0, 8'h00, 8'hFF, 8'h00, 1'b0};
        vecs[2]  = '{8'hFF, 1'b0, 8'h00, 8'hFF, 8'h00, 1'b0};
        vecs[3]  = '{8'hFF, 1'b0, 8'h00, 8'hFF, 8'h00, 1'b0};
        vecs[4]  = '{8'hFF, 1'b0, 8'h00, 8'hFF, 8'h00, 1'b0};
        vecs[5]  = '{8'hFE, 1'b0, 8'h00, 8'hFF, 8'h00, 1'b0};
        vecs[6]  = '{8'hFE, 1'b0, 8'h00, 8'hFE, 8'h00, 1'b0};
        vecs[7]  = '{8'hFE, 1'b0, 8'h00, 8'hFE, 8'h00, 1'b0};
        vecs[8]  = '{8'hFF, 1'b0, 8'h00, 8'hFE, 8'h00, 1'b0};
        vecs[9]  = '{8'hFF, 1'b0, 8'h00, 8'hFF, 8'h00, 1'b0};
        vecs[10] = '{8'hFF, 1'b0, 8'h00, 8'hFF, 8'h01, 1'b1};
        vecs[11] = '{8'hFF, 1'b1, 8'h01, 8'hFF, 8'h00, 1'b0};
        vecs[12] = '{8'hFF, 1'b0, 8'h00, 8'hFF, 8'h00, 1'b0};

        nRST     = 1'b0;
        pin_in   = 8'hFF;
        int_en   = 8'hFF;
        int_type = 8'hFF;
        int_pol  = 8'hFF;
        int_both = 8'h00;
        clr_wen  = 1'b0;
        clr_mask = 8'h00;
        #2;
        checkOutput("reset_status", 32'(status), 32'h0);
        checkOutput("reset_irq",    32'(irq),    32'h0);
        repeat (3) @(negedge CLK);
        checkOutput("reset_r_data", 32'(r_data), 32'h0);
        nRST = 1'b1;

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].pin, vecs[i].clr, vecs[i].mask);
            @(negedge CLK);
            checkOutput($sformatf("vec%0d_r_data", i), 32'(r_data), 32'(vecs[i].expR));
            checkOutput($sformatf("vec%0d_status", i), 32'(status), 32'(vecs[i].expS));
            checkOutput($sformatf("vec%0d_irq", i),    32'(irq),    32'(vecs[i].expIrq));
            checkModel($sformatf("vec%0d", i));
        end
        clr_wen = 1'b0;

        // Pin3 in both-edge mode: each direction sets, steady level does not.
        int_both = 8'h08;
        stepCycles(3, "both_cfg");
        checkOutput("both_cfg_no_evt", 32'(status[3]), 32'h0);
        pin_in[3] = 1'b0;
        stepCycles(10, "both_fall");
        checkOutput("both_fall_set", 32'(status[3]), 32'h1);
        applyStimulus(pin_in, 1'b1, 8'h08);
        stepCycles(1, "both_clr1");
        checkOutput("both_clr1", 32'(status[3]), 32'h0);
        pin_in[3] = 1'b1;
        stepCycles(10, "both_rise");
        checkOutput("both_rise_set", 32'(status[3]), 32'h1);
        applyStimulus(pin_in, 1'b1, 8'h08);
        stepCycles(1, "both_clr2");
        stepCycles(10, "both_steady");
        checkOutput("both_steady", 32'(status[3]), 32'h0);
        pin_in[3] = 1'b0;
        stepCycles(10, "both_fall2");
        checkOutput("both_fall2_set", 32'(status[3]), 32'h1);
        applyStimulus(pin_in, 1'b1, 8'h08);
        stepCycles(1, "both_clr3");

        // Pin5 level-low: clear cannot win while the level persists.
        int_type[5] = 1'b0;
        int_pol[5]  = 1'b0;
        stepCycles(3, "lvl_cfg");
        checkOutput("lvl_cfg_no_evt", 32'(status[5]), 32'h0);
        pin_in[5] = 1'b0;
        stepCycles(4, "lvl_low");
        checkOutput("lvl_low_set", 32'(status[5]), 32'h1);
        applyStimulus(pin_in, 1'b1, 8'h20);
        stepCycles(1, "lvl_clr_held");
        checkOutput("lvl_clr_held", 32'(status[5]), 32'h1);
        pin_in[5] = 1'b1;
        stepCycles(4, "lvl_high");
        applyStimulus(pin_in, 1'b1, 8'h20);
        stepCycles(1, "lvl_clr_ok");
        checkOutput("lvl_clr_ok", 32'(status[5]), 32'h0);

        // Pin2 rising edge lands on the same edge as a clear of that bit.
        pin_in[2] = 1'b0;
        stepCycles(4, "sw_low");
        pin_in[2] = 1'b1;
        stepCycles(2, "sw_sync");
        applyStimulus(pin_in, 1'b1, 8'h04);
        stepCycles(1, "sw_coincide");
        checkOutput("set_wins", 32'(status[2]), 32'h1);
        applyStimulus(pin_in, 1'b1, 8'hFF);
        stepCycles(1, "sw_clr_all");
        checkOutput("clr_all", 32'(status), 32'h0);

        // Pin1 enable masking, re-enable exposure, asynchronous reset.
        pin_in[1] = 1'b0;
        int_en[1] = 1'b0;
        stepCycles(4, "en_low");
        pin_in[1] = 1'b1;
        stepCycles(4, "en_dis_rise");
        checkOutput("en_dis_no_set", 32'(status[1]), 32'h0);
        int_en[1] = 1'b1;
        pin_in[1] = 1'b0;
        stepCycles(4, "en_fall");
        pin_in[1] = 1'b1;
        stepCycles(4, "en_rise");
        checkOutput("en_rise_set", 32'(interrupt[1]), 32'h1);
        int_en[1] = 1'b0;
        #1;
        checkOutput("dis_status",    32'(status[1]),    32'h1);
        checkOutput("dis_interrupt", 32'(interrupt[1]), 32'h0);
        checkOutput("dis_irq",       32'(irq),          32'h0);
        stepCycles(3, "dis_hold");
        int_en[1] = 1'b1;
        #1;
        checkOutput("reen_interrupt", 32'(interrupt[1]), 32'h1);
        checkOutput("reen_irq",       32'(irq),          32'h1);
        #1;
        nRST = 1'b0;
        #1;
        checkOutput("async_rst_status", 32'(status),    32'h0);
        checkOutput("async_rst_int",    32'(interrupt), 32'h0);
        checkOutput("async_rst_irq",    32'(irq),       32'h0);
        checkOutput("async_rst_rdata",  32'(r_data),    32'h0);
        @(negedge CLK);
        nRST = 1'b1;

        // Randomized traffic against the reference model, including one reset pulse.
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(3) == 0) pin_in = pin_in ^ 8'($urandom);
            if ($urandom_range(39) == 0) begin
                int_en   = 8'($urandom);
                int_type = 8'($urandom);
                int_pol  = 8'($urandom);
                int_both = 8'($urandom);
            end
            clr_wen  = ($urandom_range(5) == 0);
            clr_mask = 8'($urandom);
            nRST     = !(c >= 1200 && c < 1203);
            @(negedge CLK);
            checkModel("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
